// File: rtl/satatrn_txmux_if.sv
// Link-side and source-side signal bundle for the SATA transport TX arbiter.
// The slave modport is the arbiter; the master modport is whatever drives
// the FIS sources and the downstream ready.
interface satatrn_txmux_if #(
    parameter int NIN = 2,
    parameter int DW  = 32
);
    logic [NIN-1:0]    i_gate;
    logic [NIN-1:0]    i_src_valid;
    logic [NIN-1:0]    o_src_ready;
    logic [NIN*DW-1:0] i_src_data;
    logic [NIN-1:0]    i_src_last;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic [NIN-1:0]    o_grant;
    logic              o_busy;

    modport master (
        output i_gate, i_src_valid, i_src_data, i_src_last, i_ready,
        input  o_src_ready, o_valid, o_data, o_last, o_grant, o_busy
    );

    modport slave (
        input  i_gate, i_src_valid, i_src_data, i_src_last, i_ready,
        output o_src_ready, o_valid, o_data, o_last, o_grant, o_busy
    );
endinterface

// File: rtl/satatrn_txmux.sv
// Packet-atomic N-way FIS arbiter for the SATA transport TX path.
// Merges NIN sources onto one registered link output, optionally prefixing
// a per-channel FIS type header word. The grant only moves at packet ends.
module satatrn_txmux #(
    parameter int              NIN          = 2,
    parameter int              DW           = 32,
    parameter logic [NIN-1:0]  HDR_MASK     = 2'b10,
    parameter logic [NIN*8-1:0] HDR_WORD    = {8'h46, 8'h00},
    parameter bit              OPT_RR       = 1'b1,
    parameter bit              OPT_LOWPOWER = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    satatrn_txmux_if.slave    bus
);

    localparam int PW = (NIN > 1) ? $clog2(NIN) : 1;

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   own, own_nxt;
    logic            valid_r, valid_nxt;
    logic            last_r, last_nxt;
    logic [DW-1:0]   data_r, data_nxt;
    logic [NIN-1:0]  grant_r, grant_nxt;
    logic [NIN-1:0]  src_ready;

    logic [NIN-1:0]  elig;
    logic            adv;
    logic            found;
    logic [PW-1:0]   win;
    logic [DW-1:0]   win_data;
    logic            win_last;
    logic [DW-1:0]   own_data;
    logic            own_last;
    logic            own_valid;

    // Channel index following i, wrapping at NIN (round-robin pointer update).
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        int t;
        t = (int'(i) + 1) % NIN;
        return PW'(t);
    endfunction

    // Output registers may only change when empty or being drained.
    assign adv  = !valid_r || bus.i_ready;

    // Gated (header) channels need permission to start; others only need valid.
    assign elig = bus.i_src_valid & (~HDR_MASK | bus.i_gate);

    // Winner search: round-robin from ptr, or lowest index first.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NIN; k++) begin
            idx = OPT_RR ? (int'(ptr) + k) % NIN : k;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Mux out the candidate word for the winner and for the current owner.
    always_comb begin
        win_data  = bus.i_src_data[DW*int'(win) +: DW];
        win_last  = bus.i_src_last[win];
        own_data  = bus.i_src_data[DW*int'(own) +: DW];
        own_last  = bus.i_src_last[own];
        own_valid = bus.i_src_valid[own];
    end

    // Next-state and next-output logic for the IDLE/PASS packet FSM.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        own_nxt   = own;
        valid_nxt = valid_r;
        data_nxt  = data_r;
        last_nxt  = last_r;
        grant_nxt = grant_r;
        src_ready = '0;

        case (state)
            IDLE: begin
                if (adv) begin
                    if (!found) begin
                        valid_nxt = 1'b0;
                        if (OPT_LOWPOWER) begin
                            data_nxt = '0;
                            last_nxt = 1'b0;
                        end
                    end else if (HDR_MASK[win]) begin
                        // Header word comes from the parameter; no source word consumed yet.
                        valid_nxt      = 1'b1;
                        data_nxt       = '0;
                        data_nxt[7:0]  = HDR_WORD[8*int'(win) +: 8];
                        last_nxt       = 1'b0;
                        grant_nxt      = '0;
                        grant_nxt[win] = 1'b1;
                        own_nxt        = win;
                        state_nxt      = PASS;
                    end else begin
                        src_ready[win] = 1'b1;
                        valid_nxt      = 1'b1;
                        data_nxt       = win_data;
                        last_nxt       = win_last;
                        if (win_last) begin
                            // Single-word packet: done in the same decision.
                            ptr_nxt = next_idx(win);
                        end else begin
                            grant_nxt      = '0;
                            grant_nxt[win] = 1'b1;
                            own_nxt        = win;
                            state_nxt      = PASS;
                        end
                    end
                end
            end

            PASS: begin
                src_ready[own] = adv;
                if (adv) begin
                    valid_nxt = own_valid;
                    if (own_valid) begin
                        data_nxt = own_data;
                        last_nxt = own_last;
                    end else if (OPT_LOWPOWER) begin
                        data_nxt = '0;
                        last_nxt = 1'b0;
                    end
                    if (own_valid && own_last) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        ptr_nxt   = next_idx(own);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output pipeline register, round-robin pointer and packet owner.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr     <= '0;
            own     <= '0;
            valid_r <= 1'b0;
            data_r  <= '0;
            last_r  <= 1'b0;
            grant_r <= '0;
        end else begin
            ptr     <= ptr_nxt;
            own     <= own_nxt;
            valid_r <= valid_nxt;
            data_r  <= data_nxt;
            last_r  <= last_nxt;
            grant_r <= grant_nxt;
        end
    end

    // Sources must not see an accept while reset holds the output register.
    assign bus.o_src_ready = i_reset ? '0 : src_ready;
    assign bus.o_valid     = valid_r;
    assign bus.o_data      = data_r;
    assign bus.o_last      = last_r;
    assign bus.o_grant     = grant_r;
    assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_satatrn_txmux.sv
// Bench for satatrn_txmux: per-channel source queues drive the arbiter, and
// a per-channel expected-word scoreboard is popped as link words leave.
module tb_satatrn_txmux;

    localparam int NIN = 2;
    localparam int DW  = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } wd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    satatrn_txmux_if #(.NIN(NIN), .DW(DW)) bus ();
    satatrn_txmux_if #(.NIN(NIN), .DW(DW)) fbus ();

    satatrn_txmux #(
        .NIN(2), .DW(32), .HDR_MASK(2'b10), .HDR_WORD(16'h4600),
        .OPT_RR(1'b1), .OPT_LOWPOWER(1'b0)
    ) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus)
    );

    satatrn_txmux #(
        .NIN(2), .DW(32), .HDR_MASK(2'b10), .HDR_WORD(16'h4600),
        .OPT_RR(1'b0), .OPT_LOWPOWER(1'b0)
    ) dut_fp (
        .i_clk(clk), .i_reset(rst), .bus(fbus)
    );

    wd_t src_q0[$];
    wd_t src_q1[$];
    wd_t exp_q0[$];
    wd_t exp_q1[$];
    int  start_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cur_ch = -1;
    int          pkt_id = 0;
    bit          rnd = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] held_d;
    logic        held_l;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int ch, input int len);
        wd_t w;
        if (ch == 1) begin
            w.data = 32'h46;
            w.last = 1'b0;
            exp_q1.push_back(w);
        end
        for (int i = 0; i < len; i++) begin
            w.data = {4'(ch), 12'(pkt_id), 16'(i)};
            w.last = (i == len - 1);
            if (ch == 0) begin
                src_q0.push_back(w);
                exp_q0.push_back(w);
            end else begin
                src_q1.push_back(w);
                exp_q1.push_back(w);
            end
        end
        pkt_id++;
    endtask

    task automatic drive();
        bus.i_src_valid[0] = (src_q0.size() > 0) && (!rnd || $urandom_range(99) < 70);
        bus.i_src_data[31:0] = (src_q0.size() > 0) ? src_q0[0].data : 32'h0;
        bus.i_src_last[0] = (src_q0.size() > 0) ? src_q0[0].last : 1'b0;
        bus.i_src_valid[1] = (src_q1.size() > 0) && (!rnd || $urandom_range(99) < 70);
        bus.i_src_data[63:32] = (src_q1.size() > 0) ? src_q1[0].data : 32'h0;
        bus.i_src_last[1] = (src_q1.size() > 0) ? src_q1[0].last : 1'b0;
        bus.i_ready = !rnd || ($urandom_range(99) < 70);
    endtask

    // One link word is leaving: find its channel and match it to the scoreboard.
    task automatic consume();
        wd_t e;
        int  ch;
        int  avail;
        ch = (cur_ch >= 0) ? cur_ch : ((bus.o_data == 32'h46) ? 1 : int'(bus.o_data[31:28]));
        avail = (ch == 0) ? exp_q0.size() : ((ch == 1) ? exp_q1.size() : 0);
        chk("sb_word_expected", 64'(avail > 0), 64'd1);
        if (avail == 0) return;
        if (cur_ch < 0) start_q.push_back(ch);
        e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("out_data", 64'(bus.o_data), 64'(e.data));
        chk("out_last", 64'(bus.o_last), 64'(e.last));
        chk("out_grant", 64'(bus.o_grant), e.last ? 64'd0 : 64'(1 << ch));
        cur_ch = e.last ? -1 : ch;
    endtask

    task automatic cycle();
        bit pop0;
        bit pop1;
        @(negedge clk);
        pop0 = bus.i_src_valid[0] && bus.o_src_ready[0];
        pop1 = bus.i_src_valid[1] && bus.o_src_ready[1];
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.o_valid), 64'd1);
                chk("stall_data", 64'(bus.o_data), 64'(held_d));
                chk("stall_last", 64'(bus.o_last), 64'(held_l));
            end
            stall_prev = bus.o_valid && !bus.i_ready;
            held_d = bus.o_data;
            held_l = bus.o_last;
            if (bus.o_valid && bus.i_ready) consume();
        end
        @(posedge clk);
        #1;
        if (pop0 && src_q0.size() > 0) void'(src_q0.pop_front());
        if (pop1 && src_q1.size() > 0) void'(src_q1.pop_front());
        drive();
    endtask

    task automatic clear_sb();
        src_q0.delete();
        src_q1.delete();
        exp_q0.delete();
        exp_q1.delete();
        cur_ch = -1;
        stall_prev = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        clear_sb();
        drive();
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while ((src_q0.size() > 0 || src_q1.size() > 0 || exp_q0.size() > 0 ||
                exp_q1.size() > 0 || cur_ch >= 0) && n < max) begin
            cycle();
            n++;
        end
        chk(tag, 64'(n < max), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        fbus.i_gate = '0;
        fbus.i_src_valid = '0;
        fbus.i_src_data = '0;
        fbus.i_src_last = '0;
        fbus.i_ready = 1'b0;

        // Reset with every input high.
        bus.i_gate = '1;
        bus.i_src_valid = '1;
        bus.i_src_last = '1;
        bus.i_src_data = '1;
        bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_data", 64'(bus.o_data), 64'd0);
        chk("rst_last", 64'(bus.o_last), 64'd0);
        chk("rst_grant", 64'(bus.o_grant), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_src_ready", 64'(bus.o_src_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_no_word_yet", 64'(bus.o_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.i_src_valid = '0;
        bus.i_src_last = '0;
        bus.i_src_data = '0;
        chk("first_valid", 64'(bus.o_valid), 64'd1);
        chk("first_data", 64'(bus.o_data), 64'hFFFF_FFFF);
        chk("first_last", 64'(bus.o_last), 64'd1);
        chk("first_grant", 64'(bus.o_grant), 64'd0);

        // ch0 3-word packet.
        do_reset(2);
        add_pkt(0, 3);
        drain("drain_ch0_pkt", 100);

        // ch1 held off by gate while ch0 proceeds, then released.
        bus.i_gate = 2'b01;
        add_pkt(1, 2);
        add_pkt(0, 3);
        repeat (20) cycle();
        chk("gate_hold_src", 64'(src_q1.size()), 64'd2);
        chk("gate_hold_exp", 64'(exp_q1.size()), 64'd3);
        chk("gate_ch0_done", 64'(exp_q0.size()), 64'd0);
        bus.i_gate = 2'b11;
        drain("drain_gate_release", 100);

        // Continuous requests from both: round-robin alternation from ptr=0.
        do_reset(2);
        start_q.delete();
        for (int i = 0; i < 3; i++) begin
            add_pkt(0, 2);
            add_pkt(1, 2);
        end
        drain("drain_rr", 200);
        chk("rr_count", 64'(start_q.size()), 64'd6);
        if (start_q.size() >= 4) begin
            chk("rr_order0", 64'(start_q[0]), 64'd0);
            chk("rr_order1", 64'(start_q[1]), 64'd1);
            chk("rr_order2", 64'(start_q[2]), 64'd0);
            chk("rr_order3", 64'(start_q[3]), 64'd1);
        end

        // Fixed priority: ch0 always requesting starves ch1.
        fbus.i_gate = 2'b11;
        fbus.i_src_valid = 2'b11;
        fbus.i_src_last = 2'b11;
        fbus.i_src_data = {32'hB1B1_0000, 32'hA0A0_0000};
        fbus.i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("fp_valid", 64'(fbus.o_valid), 64'd1);
            chk("fp_data", 64'(fbus.o_data), 64'hA0A0_0000);
            chk("fp_ready1", 64'(fbus.o_src_ready[1]), 64'd0);
        end
        fbus.i_src_valid = '0;

        // Gate drop mid-packet does not abort the packet.
        bus.i_gate = 2'b11;
        add_pkt(1, 5);
        n = 0;
        while (cur_ch != 1 && n < 50) begin
            cycle();
            n++;
        end
        chk("gate_drop_started", 64'(cur_ch == 1), 64'd1);
        bus.i_gate = 2'b01;
        drain("drain_gate_drop", 100);
        bus.i_gate = 2'b11;

        // Reset mid-packet, then a fresh packet restarts with its header.
        add_pkt(1, 6);
        n = 0;
        while (cur_ch != 1 && n < 50) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("mid_busy", 64'(bus.o_busy), 64'd1);
        do_reset(2);
        chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("mid_rst_grant", 64'(bus.o_grant), 64'd0);
        chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
        start_q.delete();
        add_pkt(1, 2);
        drain("drain_after_rst", 100);
        chk("after_rst_start", 64'(start_q.size()), 64'd1);

        // 100 random packets with source bubbles and downstream stalls.
        rnd = 1'b1;
        for (int i = 0; i < 100; i++) begin
            add_pkt(int'($urandom_range(1)), int'($urandom_range(1, 5)));
        end
        drain("drain_random", 20000);
        rnd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
